// File: rtl/reg_bus_pkg.sv
// Shared types and defaults for the peripheral register bus.
// Imported by the arbiter, the register wrapper and the peripherals.
package reg_bus_pkg;

    localparam int NUM_MASTERS = 2;
    localparam int DEF_ADDR_W  = 7;
    localparam int DEF_DATA_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant.
// When both masters request, the one not granted last wins.
module rr_arb2
    import reg_bus_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   last_gnt,
    output logic                   gnt_valid,
    output logic                   gnt_idx
);

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = 1'b0;
        case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ~last_gnt;
            default: gnt_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Two-master arbiter for the shared peripheral register bus.
// Serialises accesses, drives single-cycle strobes and returns read data with an ack pulse.
module reg_bus_arbiter
    import reg_bus_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_wr_en,
    output logic              bus_rd_en,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,

    output logic              busy,
    output logic              gnt_id
);

    localparam logic [3:0] RD_LAT_V = 4'(RD_LAT);

    state_t            state;
    state_t            state_next;
    logic [3:0]        lat_cnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              last_gnt;
    logic              gnt_valid;
    logic              gnt_idx;
    logic              capture;

    rr_arb2 u_arb (
        .req       ({m1_req, m0_req}),
        .last_gnt  (last_gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        bus_wr_en  = 1'b0;
        bus_rd_en  = 1'b0;
        m0_ack     = 1'b0;
        m1_ack     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_valid) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                bus_wr_en  = lat_we;
                bus_rd_en  = ~lat_we;
                state_next = lat_we ? DONE : WAIT;
            end
            WAIT: begin
                if (lat_cnt == 4'd1) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                m0_ack     = ~gnt_id;
                m1_ack     = gnt_id;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Master inputs are only looked at in IDLE; the latched copy drives the bus afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            gnt_id    <= 1'b0;
            last_gnt  <= 1'b1;
            lat_cnt   <= 4'd0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            if (state == IDLE && gnt_valid) begin
                lat_we    <= gnt_idx ? m1_we    : m0_we;
                lat_addr  <= gnt_idx ? m1_addr  : m0_addr;
                lat_wdata <= gnt_idx ? m1_wdata : m0_wdata;
                gnt_id    <= gnt_idx;
                last_gnt  <= gnt_idx;
            end
            if (state == ACCESS && !lat_we) begin
                lat_cnt <= RD_LAT_V;
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt - 4'd1;
            end
            if (capture) begin
                if (gnt_id) begin
                    m1_rdata <= bus_rdata;
                end else begin
                    m0_rdata <= bus_rdata;
                end
            end
        end
    end

    assign bus_addr  = lat_addr;
    assign bus_wdata = lat_wdata;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboard bench for reg_bus_arbiter: RD_LAT=1 instance with a register-file peripheral,
// plus an RD_LAT=4 instance for the long-latency read case.
module tb_reg_bus_arbiter;

    typedef struct {
        bit         mid;
        bit         we;
        logic [6:0] addr;
        logic [7:0] wdata;
        int         cyc;
    } bus_exp_t;

    typedef struct {
        bit         mid;
        logic [7:0] rdata;
        int         cyc;
    } ack_exp_t;

    logic       clk;
    logic       reset;
    logic       m0_req, m0_we, m1_req, m1_we;
    logic [6:0] m0_addr, m1_addr;
    logic [7:0] m0_wdata, m1_wdata;
    logic       m0_ack, m1_ack;
    logic [7:0] m0_rdata, m1_rdata;
    logic [6:0] bus_addr;
    logic       bus_wr_en, bus_rd_en;
    logic [7:0] bus_wdata, bus_rdata;
    logic       busy, gnt_id;

    logic       d4_m0_req, d4_m0_we, d4_m0_ack, d4_m1_ack;
    logic [6:0] d4_m0_addr, d4_bus_addr;
    logic [7:0] d4_m0_rdata, d4_m1_rdata, d4_bus_wdata, d4_bus_rdata;
    logic       d4_bus_wr_en, d4_bus_rd_en, d4_busy, d4_gnt_id;

    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    bus_exp_t   bus_q[$];
    ack_exp_t   ack_q[$];

    logic [7:0] mem [0:127];
    logic [7:0] rd_q;
    logic       rd_v;
    logic       poke;
    logic [6:0] poke_addr;
    logic [7:0] poke_data;
    logic [3:0] pipe4;

    reg_bus_arbiter #(.ADDR_W(7), .DATA_W(8), .RD_LAT(1)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .bus_addr(bus_addr), .bus_wr_en(bus_wr_en), .bus_rd_en(bus_rd_en),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .busy(busy), .gnt_id(gnt_id)
    );

    reg_bus_arbiter #(.ADDR_W(7), .DATA_W(8), .RD_LAT(4)) dut4 (
        .clk(clk), .reset(reset),
        .m0_req(d4_m0_req), .m0_we(d4_m0_we), .m0_addr(d4_m0_addr), .m0_wdata(8'h00),
        .m0_ack(d4_m0_ack), .m0_rdata(d4_m0_rdata),
        .m1_req(1'b0), .m1_we(1'b0), .m1_addr(7'h00), .m1_wdata(8'h00),
        .m1_ack(d4_m1_ack), .m1_rdata(d4_m1_rdata),
        .bus_addr(d4_bus_addr), .bus_wr_en(d4_bus_wr_en), .bus_rd_en(d4_bus_rd_en),
        .bus_wdata(d4_bus_wdata), .bus_rdata(d4_bus_rdata),
        .busy(d4_busy), .gnt_id(d4_gnt_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register-file peripheral: read data is valid exactly one cycle after the strobe, 0 otherwise.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
            rd_v <= 1'b0;
            rd_q <= 8'h00;
        end else begin
            if (bus_wr_en) mem[bus_addr] <= bus_wdata;
            if (poke) mem[poke_addr] <= poke_data;
            rd_v <= bus_rd_en;
            if (bus_rd_en) rd_q <= mem[bus_addr];
        end
    end
    assign bus_rdata = rd_v ? rd_q : 8'h00;

    // Four-cycle peripheral: 5C appears only in the cycle RD_LAT after the strobe.
    always @(posedge clk) begin
        if (reset) pipe4 <= 4'h0;
        else       pipe4 <= {pipe4[2:0], d4_bus_rd_en};
    end
    assign d4_bus_rdata = pipe4[3] ? 8'h5C : 8'h00;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: actual %0h, required %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input bit mid, input bit req, input bit we,
                                 input logic [6:0] addr, input logic [7:0] wdata);
        if (mid) begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    function automatic void pushBus(input bit mid, input bit we, input logic [6:0] addr,
                                    input logic [7:0] wdata, input int at);
        bus_exp_t e;
        e.mid = mid; e.we = we; e.addr = addr; e.wdata = wdata; e.cyc = at;
        bus_q.push_back(e);
    endfunction

    function automatic void pushAck(input bit mid, input logic [7:0] rdata, input int at);
        ack_exp_t e;
        e.mid = mid; e.rdata = rdata; e.cyc = at;
        ack_q.push_back(e);
    endfunction

    // Issues n back-to-back transactions, keeping req high across acks, then drops req.
    task automatic masterLoop(input bit mid, input int n, input bit we,
                              input logic [6:0] addr0, input logic [7:0] data0);
        bit got;
        for (int i = 0; i < n; i++) begin
            applyStimulus(mid, 1'b1, we, 7'(addr0 + 7'(i)), 8'(data0 + 8'(i)));
            got = 1'b0;
            for (int t = 0; t < 40 && !got; t++) begin
                @(negedge clk);
                if (mid ? m1_ack : m0_ack) got = 1'b1;
            end
            if (!got) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL ack_timeout m%0d: actual no ack, required ack", mid);
            end
        end
        applyStimulus(mid, 1'b0, 1'b0, 7'h00, 8'h00);
    endtask

    // Monitor: every strobe and every ack must match the head of its expectation queue.
    always @(negedge clk) begin
        bus_exp_t be;
        ack_exp_t ae;
        if (!reset) begin
            if (bus_wr_en || bus_rd_en) begin
                checkOutput("strobe_overlap", 32'(bus_wr_en & bus_rd_en), 32'd0);
                if (bus_q.size() == 0) begin
                    checkOutput("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    be = bus_q.pop_front();
                    checkOutput("strobe_we", 32'(bus_wr_en), 32'(be.we));
                    checkOutput("bus_addr", 32'(bus_addr), 32'(be.addr));
                    if (be.we) checkOutput("bus_wdata", 32'(bus_wdata), 32'(be.wdata));
                    checkOutput("gnt_id", 32'(gnt_id), 32'(be.mid));
                    checkOutput("strobe_cycle", 32'(cyc), 32'(be.cyc));
                end
            end
            if (m0_ack || m1_ack) begin
                checkOutput("ack_overlap", 32'(m0_ack & m1_ack), 32'd0);
                if (ack_q.size() == 0) begin
                    checkOutput("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    ae = ack_q.pop_front();
                    checkOutput("ack_master", 32'(m1_ack), 32'(ae.mid));
                    checkOutput("ack_rdata", 32'(ae.mid ? m1_rdata : m0_rdata), 32'(ae.rdata));
                    checkOutput("ack_cycle", 32'(cyc), 32'(ae.cyc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual still running, required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;
        reset = 1'b1;
        poke = 1'b0; poke_addr = 7'h00; poke_data = 8'h00;
        d4_m0_req = 1'b0; d4_m0_we = 1'b0; d4_m0_addr = 7'h00;
        applyStimulus(1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 7'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_gnt_id", 32'(gnt_id), 32'd0);
        checkOutput("rst_bus_addr", 32'(bus_addr), 32'd0);
        checkOutput("rst_bus_wdata", 32'(bus_wdata), 32'd0);
        checkOutput("rst_strobes", 32'({bus_wr_en, bus_rd_en}), 32'd0);
        checkOutput("rst_acks", 32'({m0_ack, m1_ack}), 32'd0);
        checkOutput("rst_rdata", 32'({m0_rdata, m1_rdata}), 32'd0);

        // Reset lands in the WAIT cycle of an m0 read: everything clears, no ack follows.
        @(posedge clk); #1; c = cyc;
        pushBus(1'b0, 1'b0, 7'h10, 8'h00, c + 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 7'h10, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_bus_addr", 32'(bus_addr), 32'd0);
        checkOutput("midrst_strobes", 32'({bus_wr_en, bus_rd_en}), 32'd0);
        checkOutput("midrst_ack", 32'(m0_ack), 32'd0);
        checkOutput("midrst_gnt_id", 32'(gnt_id), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("midrst_no_ack_rdata", 32'(m0_rdata), 32'd0);

        // Single write from m0.
        @(posedge clk); #1; c = cyc;
        pushBus(1'b0, 1'b1, 7'h26, 8'hFA, c + 1);
        pushAck(1'b0, 8'h00, c + 2);
        masterLoop(1'b0, 1, 1'b1, 7'h26, 8'hFA);
        @(negedge clk);
        checkOutput("gpo_written", 32'(mem[7'h26]), 32'hFA);

        // m0 reads the same register back.
        @(posedge clk); #1; c = cyc;
        pushBus(1'b0, 1'b0, 7'h26, 8'h00, c + 1);
        pushAck(1'b0, 8'hFA, c + 3);
        masterLoop(1'b0, 1, 1'b0, 7'h26, 8'h00);

        // Peripheral now holds C3; m1 reads it, m0's held data must not move.
        @(posedge clk); #1;
        poke = 1'b1; poke_addr = 7'h26; poke_data = 8'hC3;
        @(posedge clk); #1;
        poke = 1'b0;
        c = cyc;
        pushBus(1'b1, 1'b0, 7'h26, 8'h00, c + 1);
        pushAck(1'b1, 8'hC3, c + 3);
        masterLoop(1'b1, 1, 1'b0, 7'h26, 8'h00);
        @(negedge clk);
        checkOutput("m0_rdata_held", 32'(m0_rdata), 32'hFA);

        // Fresh reset, then both masters at once: m0 preferred first.
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1; c = cyc;
        pushBus(1'b0, 1'b1, 7'h3A, 8'hA5, c + 1);
        pushAck(1'b0, 8'h00, c + 2);
        pushBus(1'b1, 1'b0, 7'h3A, 8'h00, c + 4);
        pushAck(1'b1, 8'hA5, c + 6);
        fork
            masterLoop(1'b0, 1, 1'b1, 7'h3A, 8'hA5);
            masterLoop(1'b1, 1, 1'b0, 7'h3A, 8'h00);
        join

        // Both masters hold req for three writes each: grants alternate starting with m0.
        @(posedge clk); #1; c = cyc;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) begin
                pushBus(1'b0, 1'b1, 7'(7'h40 + 7'(k / 2)), 8'(8'h10 + 8'(k / 2)), c + 1 + 3 * k);
                pushAck(1'b0, 8'h00, c + 2 + 3 * k);
            end else begin
                pushBus(1'b1, 1'b1, 7'(7'h50 + 7'(k / 2)), 8'(8'h20 + 8'(k / 2)), c + 1 + 3 * k);
                pushAck(1'b1, 8'hA5, c + 2 + 3 * k);
            end
        end
        fork
            masterLoop(1'b0, 3, 1'b1, 7'h40, 8'h10);
            masterLoop(1'b1, 3, 1'b1, 7'h50, 8'h20);
        join
        repeat (3) @(negedge clk);
        checkOutput("fair_mem_m0", 32'(mem[7'h42]), 32'h12);
        checkOutput("fair_mem_m1", 32'(mem[7'h52]), 32'h22);

        // RD_LAT=4 instance: req dropped right after the grant, ack still arrives.
        @(posedge clk); #1; c = cyc;
        d4_m0_req = 1'b1; d4_m0_we = 1'b0; d4_m0_addr = 7'h11;
        @(negedge clk);
        checkOutput("lat4_busy_pre", 32'(d4_busy), 32'd0);
        @(posedge clk); #1;
        d4_m0_req = 1'b0; d4_m0_addr = 7'h00;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checkOutput("lat4_busy", 32'(d4_busy), 32'(cyc >= c + 1 && cyc <= c + 6));
            checkOutput("lat4_rd_en", 32'(d4_bus_rd_en), 32'(cyc == c + 1));
            checkOutput("lat4_ack", 32'(d4_m0_ack), 32'(cyc == c + 6));
            if (cyc == c + 6) checkOutput("lat4_rdata", 32'(d4_m0_rdata), 32'h5C);
        end
        checkOutput("lat4_addr", 32'(d4_bus_addr), 32'h11);

        repeat (3) @(negedge clk);
        checkOutput("bus_q_drained", 32'(bus_q.size()), 32'd0);
        checkOutput("ack_q_drained", 32'(ack_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
